// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch unit.
//   ADDR_W / INSTR_W : PC and instruction widths
//   fetch_state_t    : fetch FSM states
//   fetch_entry_t    : buffered fetch result {pc, instr}
package instr_fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/clear.
//   clk, rst : clock, synchronous active-high reset
//   clear_i  : empties the FIFO (wins over push/pop)
//   push_i   : write entry_i (caller guarantees space)
//   pop_i    : drop head entry (caller guarantees non-empty)
//   head_o   : current head entry
//   count_o  : number of stored entries
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     entry_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = entry_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with a small
// buffer of fetched {pc, instr} entries for decode.
//   pc_i / stall_en_o / flush_i     : program counter side (PC held while stall_en_o)
//   imem_req_o / imem_addr_o / imem_gnt_i / imem_rvalid_i / imem_rdata_i : memory side
//   instr_valid_o / instr_o / instr_pc_o / instr_ready_i                  : decode side
// Optional feature macro FETCH_BYPASS_EN: a response arriving while the buffer
// is empty is presented to decode in the same cycle.
module instr_fetch #(
    parameter int ADDR_W     = instr_fetch_pkg::ADDR_W,
    parameter int INSTR_W    = instr_fetch_pkg::INSTR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               flush_i,
    output logic               stall_en_o,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               instr_ready_i
);

    import instr_fetch_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_req_q, pc_req_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_after;
    fetch_entry_t       fifo_head;
    fetch_entry_t       push_entry;
    logic               fifo_valid;
    logic               rsp_live;
    logic               push;
    logic               pop;
    logic               req;
    logic               granted;

    assign fifo_valid = (fifo_count != '0);
    // A response that is actually kept: only in WAIT_RSP and not killed by a redirect.
    assign rsp_live   = !rst && (state_q == WAIT_RSP) && imem_rvalid_i && !flush_i;
    assign pop        = !rst && !flush_i && fifo_valid && instr_ready_i;
    assign push_entry = '{pc: pc_req_q, instr: imem_rdata_i};

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass        = rsp_live && !fifo_valid;
    assign push          = rsp_live && !(bypass && instr_ready_i);
    assign instr_valid_o = fifo_valid || bypass;
    assign instr_o       = bypass ? imem_rdata_i : fifo_head.instr;
    assign instr_pc_o    = bypass ? pc_req_q     : fifo_head.pc;
`else
    assign push          = rsp_live;
    assign instr_valid_o = fifo_valid;
    assign instr_o       = fifo_head.instr;
    assign instr_pc_o    = fifo_head.pc;
`endif

    // Occupancy once this cycle's push/pop settle; a follow-on request is only
    // issued when its response is guaranteed a slot.
    assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req = !flush_i && (fifo_count < CNT_W'(FIFO_DEPTH));
                if (req) begin
                    state_d = imem_gnt_i ? WAIT_RSP : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                req = !flush_i;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (imem_gnt_i) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (flush_i) begin
                    // A response landing with the flush is the outstanding one, so
                    // nothing remains to drain.
                    state_d = imem_rvalid_i ? IDLE : DRAIN;
                end else if (imem_rvalid_i) begin
                    req = (count_after < CNT_W'(FIFO_DEPTH));
                    if (req) begin
                        state_d = imem_gnt_i ? WAIT_RSP : WAIT_GNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // Further flushes keep us here; only the stale response ends the drain.
                if (imem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            req = 1'b0;
        end
    end

    assign granted  = req && imem_gnt_i;
    assign pc_req_d = granted ? pc_i : pc_req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_req_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_req_q <= pc_req_d;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc_i;
    assign stall_en_o  = rst || (!granted && !flush_i);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush_i),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a PC/memory environment plus a decode-side
// model (decode must see a gap-free, PC-ordered stream restarting at each redirect).
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_i;
    logic        flush_i;
    logic        stall_en_o;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [15:0] instr_pc_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W     (16),
        .INSTR_W    (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .stall_en_o    (stall_en_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory image: address 0 holds addi x1,x0,5; elsewhere a tagged pattern.
    function automatic logic [31:0] instr_of(input logic [15:0] a);
        if (a == 16'h0000) return 32'h00500093;
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Environment state (PC register and memory)
    logic [15:0] pc           = '0;
    logic [15:0] rsp_addr     = '0;
    logic [15:0] flush_target = '0;
    bit          rsp_pending  = 0;
    bit          flush_now    = 0;
    bit          ready        = 1;
    int          rsp_cnt      = 0;
    int          gnt_delay    = 0;
    int          rsp_delay    = 1;
    int          req_wait     = 0;
    int          cyc          = 0;
    int          hold_cnt     = 0;

    int          grant_cyc[$];
    logic [15:0] grant_addr[$];
    int          rvalid_cyc[$];
    int          acc_cyc[$];
    logic [15:0] acc_pc[$];
    logic [31:0] acc_instr[$];

    function automatic void clear_logs();
        grant_cyc.delete();
        grant_addr.delete();
        rvalid_cyc.delete();
        acc_cyc.delete();
        acc_pc.delete();
        acc_instr.delete();
        hold_cnt = 0;
    endfunction

    task automatic cycle();
        bit          c_req, c_gnt, c_rv, c_stall, c_valid, c_flush, c_rst;
        logic [15:0] c_addr, c_ipc;
        logic [31:0] c_instr;
        @(negedge clk);
        pc_i          = pc;
        flush_i       = flush_now;
        instr_ready_i = ready;
        imem_rvalid_i = rsp_pending && (rsp_cnt == 0);
        imem_rdata_i  = imem_rvalid_i ? instr_of(rsp_addr) : 32'hDEADBEEF;
        imem_gnt_i    = 1'b0;
        #1;
        imem_gnt_i    = imem_req_o && (req_wait >= gnt_delay);
        #1;
        c_req   = imem_req_o;
        c_gnt   = imem_req_o && imem_gnt_i;
        c_rv    = imem_rvalid_i;
        c_stall = stall_en_o;
        c_valid = instr_valid_o;
        c_flush = flush_i;
        c_rst   = rst;
        c_addr  = imem_addr_o;
        c_ipc   = instr_pc_o;
        c_instr = instr_o;
        @(posedge clk);
        if (!c_rst) begin
            if (c_gnt) begin
                grant_cyc.push_back(cyc);
                grant_addr.push_back(c_addr);
            end
            if (c_req && !c_gnt) hold_cnt++;
            if (c_rv) rvalid_cyc.push_back(cyc);
            if (c_valid && ready && !c_flush) begin
                acc_cyc.push_back(cyc);
                acc_pc.push_back(c_ipc);
                acc_instr.push_back(c_instr);
            end
        end
        if (c_rst) begin
            rsp_pending = 0;
            req_wait    = 0;
            pc          = '0;
        end else begin
            if (c_rv) rsp_pending = 0;
            else if (rsp_pending) rsp_cnt--;
            if (c_gnt) begin
                rsp_pending = 1;
                rsp_addr    = c_addr;
                rsp_cnt     = rsp_delay - 1;
                req_wait    = 0;
            end else if (c_req) begin
                req_wait++;
            end else begin
                req_wait = 0;
            end
            if (c_flush) pc = flush_target;
            else if (!c_stall) pc = pc + 16'd4;
        end
        flush_now = 0;
        cyc++;
    endtask

    // Compare process: interface rules and the decode-stream model, every cycle.
    logic [15:0] exp_pc = '0;
    logic [15:0] p_addr = '0;
    bit          p_hold = 0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_pc = '0;
            p_hold = 0;
        end else begin
            if (imem_req_o) check("addr_eq_pc", 32'(imem_addr_o), 32'(pc_i));
            check("stall_rule", 32'(stall_en_o), 32'(!(imem_req_o && imem_gnt_i) && !flush_i));
            if (p_hold && !flush_i) begin
                check("req_held", 32'(imem_req_o), 32'd1);
                check("addr_held", 32'(imem_addr_o), 32'(p_addr));
            end
            if (instr_valid_o && instr_ready_i && !flush_i) begin
                check("dec_pc", 32'(instr_pc_o), 32'(exp_pc));
                check("dec_instr", instr_o, instr_of(exp_pc));
                exp_pc = exp_pc + 16'd4;
            end
            if (flush_i) exp_pc = flush_target;
            p_hold = imem_req_o && !imem_gnt_i && !flush_i;
            p_addr = imem_addr_o;
        end
    end

    task automatic check_reset_outputs(input string tag);
        #1;
        check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
        check({tag, "_req"},   32'(imem_req_o),    32'd0);
        check({tag, "_stall"}, 32'(stall_en_o),    32'd1);
        check({tag, "_instr"}, instr_o,            32'd0);
        check({tag, "_ipc"},   32'(instr_pc_o),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int xg;
        pc_i          = '0;
        flush_i       = 1'b0;
        instr_ready_i = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) cycle();
        check_reset_outputs("rst");

        // Back-to-back fetch from reset
        clear_logs();
        ready = 1; gnt_delay = 0; rsp_delay = 1;
        rst = 1'b0;
        t0 = cyc;
        repeat (6) cycle();
        check("t1_n_grants", 32'(grant_addr.size() >= 3), 32'd1);
        check("t1_addr0", 32'(grant_addr[0]), 32'h0000);
        check("t1_addr1", 32'(grant_addr[1]), 32'h0004);
        check("t1_addr2", 32'(grant_addr[2]), 32'h0008);
        check("t1_first_req_cyc", 32'(grant_cyc[0]), 32'(t0));
        check("t1_back_to_back", 32'(grant_cyc[2] - grant_cyc[0]), 32'd2);
        check("t1_acc_pc0", 32'(acc_pc[0]), 32'h0000);
        check("t1_acc_pc1", 32'(acc_pc[1]), 32'h0004);
        check("t1_acc_pc2", 32'(acc_pc[2]), 32'h0008);
        check("t1_acc_instr0", acc_instr[0], 32'h00500093);
        check("t1_latency", 32'(acc_cyc[0] - rvalid_cyc[0]), 32'(LAT));
        check("t1_throughput", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);

        // Grant delayed three cycles
        clear_logs();
        gnt_delay = 3;
        for (int i = 0; i < 20 && grant_addr.size() == 0; i++) cycle();
        check("t2_grant_seen", 32'(grant_addr.size() != 0), 32'd1);
        check("t2_hold_cycles", 32'(hold_cnt), 32'd3);
        check("t2_pc_once", 32'(pc), 32'(grant_addr[0] + 16'd4));
        gnt_delay = 0;

        // Reset while a response is outstanding
        clear_logs();
        rsp_delay = 3;
        for (int i = 0; i < 20 && grant_addr.size() == 0; i++) cycle();
        check("t4_grant_seen", 32'(grant_addr.size() != 0), 32'd1);
        rst = 1'b1;
        cycle();
        check_reset_outputs("t4");
        clear_logs();
        rsp_delay = 1;
        rst = 1'b0;
        t0 = cyc;
        repeat (4) cycle();
        check("t4_restart_addr", 32'(grant_addr[0]), 32'h0000);
        check("t4_restart_cyc", 32'(grant_cyc[0]), 32'(t0));
        check("t4_restart_acc", 32'(acc_pc[0]), 32'h0000);

        // Redirect while the response for 0x0010 is outstanding
        clear_logs();
        rsp_delay = 3;
        xg = -1;
        for (int i = 0; i < 40 && xg < 0; i++) begin
            cycle();
            foreach (grant_addr[k]) if (grant_addr[k] == 16'h0010) xg = grant_cyc[k];
        end
        check("t5_grant_0010", 32'(xg >= 0), 32'd1);
        cycle();
        flush_target = 16'h0040;
        flush_now    = 1;
        cycle();
        clear_logs();
        rsp_delay = 1;
        for (int i = 0; i < 20 && acc_pc.size() < 2; i++) cycle();
        check("t5_acc_count", 32'(acc_pc.size() >= 2), 32'd1);
        check("t5_first_pc", 32'(acc_pc[0]), 32'h0040);
        check("t5_first_instr", acc_instr[0], 32'h5A1A0040);
        check("t5_second_pc", 32'(acc_pc[1]), 32'h0044);
        check("t5_first_req", 32'(grant_addr[0]), 32'h0040);
        check("t5_no_req_in_drain", 32'(grant_cyc[0] > rvalid_cyc[0]), 32'd1);

        // Decode back-pressure for ten cycles from a fresh start
        rst = 1'b1;
        cycle();
        ready = 0;
        rsp_delay = 1;
        clear_logs();
        rst = 1'b0;
        repeat (10) cycle();
        check("t3_grants", 32'(grant_addr.size()), 32'(DEPTH));
        check("t3_none_acc", 32'(acc_pc.size()), 32'd0);
        #1;
        check("t3_valid_held", 32'(instr_valid_o), 32'd1);
        check("t3_head_pc", 32'(instr_pc_o), 32'h0000);
        ready = 1;
        repeat (6) cycle();
        check("t3_drain_pc0", 32'(acc_pc[0]), 32'h0000);
        check("t3_drain_pc1", 32'(acc_pc[1]), 32'h0004);
        check("t3_drain_pc2", 32'(acc_pc[2]), 32'h0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: consumes the 16-bit program counter, issues single-outstanding requests to instruction memory, and buffers returned instructions with their PCs for decode. Sits between the program counter (drives its stall input, observes its redirect) and the decode stage. It is the reader side of the PC interface and the initiator on the instruction-memory request/grant/response interface.

## Interface
- ADDR_W, 16, PC/address width
- INSTR_W, 32, instruction width
- FIFO_DEPTH, 2, fetched-instruction buffer entries (power of two, ≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- pc_i  in  ADDR_W  current PC from program counter
- flush_i  in  1  redirect (branch/jal/jalr) taken this cycle
- stall_en_o  out  1  holds PC; low only when PC must advance
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  ADDR_W  request address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  INSTR_W  response instruction
- instr_valid_o  out  1  instruction available to decode
- instr_o  out  INSTR_W  instruction
- instr_pc_o  out  ADDR_W  PC of instr_o
- instr_ready_i  in  1  decode accepts instruction

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RSP, DRAIN.
- IDLE: imem_req_o = 1 when no flush_i and (fifo_count + outstanding) < FIFO_DEPTH; grant → WAIT_RSP, else → WAIT_GNT.
- WAIT_GNT: imem_req_o held high, imem_addr_o stable (= pc_i, PC frozen); grant → WAIT_RSP.
- WAIT_RSP: on imem_rvalid_i push {pc_req, imem_rdata_i} into FIFO; same cycle may issue next request if space → WAIT_RSP/WAIT_GNT, else IDLE.
- pc_req register captures imem_addr_o on grant.
- imem_addr_o = pc_i combinationally.
- stall_en_o = !(imem_req_o && imem_gnt_i) && !flush_i: PC advances exactly once per granted request, or on redirect.
- flush_i: FIFO emptied, no new request that cycle; if a response is outstanding (WAIT_RSP) → DRAIN, else IDLE. WAIT_GNT request withdrawn on flush (req only legal to drop on flush).
- DRAIN: imem_rvalid_i discarded (not pushed), → IDLE. flush_i in DRAIN stays in DRAIN.
- Output: instr_valid_o = FIFO not empty; pop on instr_valid_o && instr_ready_i.
- Simultaneous push and pop at full: allowed only via count accounting; request never issued without a guaranteed slot, so FIFO never overflows.
- Simultaneous flush_i and rvalid: response dropped. Flush and pop: FIFO cleared, pop ignored.
- Reset: state IDLE, FIFO empty, pc_req 0, instr_valid_o 0, imem_req_o 0, stall_en_o 1, instr_o/instr_pc_o 0. Reset mid-transaction abandons outstanding response; memory side is reset in same cycle.

## Timing
- Request issued the cycle after reset deassertion earliest.
- Response earliest one cycle after grant; arbitrary wait allowed.
- Default: instr_valid_o rises one cycle after imem_rvalid_i (FIFO registered).
- Sustained throughput: one instruction per cycle with single-cycle grant/response and FIFO_DEPTH ≥ 2.
- Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

## Configuration
- FETCH_BYPASS_EN defined: when FIFO empty and imem_rvalid_i (not DRAIN, no flush_i), response drives instr_valid_o/instr_o/instr_pc_o same cycle; if instr_ready_i it is not pushed, else pushed. Zero-cycle fetch-to-decode latency.
- Undefined: all responses pass through FIFO, one-cycle latency; no combinational path from imem_rdata_i to instr_o.

## Structure
- Shared core package: ADDR_W/INSTR_W constants, fetch_state_t enum (IDLE, WAIT_GNT, WAIT_RSP, DRAIN), fetch_entry_t struct {pc, instr}.
- One sub-module: fetch_fifo (synchronous FIFO of fetch_entry_t, push/pop/clear, count output).

## Test plan
- Reset then memory granting immediately, responding next cycle, ready=1: addresses 0x0000,0x0004,0x0008 issued on consecutive cycles; instr_pc_o sequence 0x0000,0x0004,0x0008.
- Grant delayed 3 cycles: imem_req_o/imem_addr_o stable, stall_en_o=1 for 3 cycles, PC advances once on grant.
- instr_ready_i=0 for 10 cycles: exactly FIFO_DEPTH instructions buffered, no further requests, no overflow; release drains in order.
- flush_i while response outstanding for 0x0010: rvalid data dropped in DRAIN, next fetched instr_pc_o equals redirect target (e.g. 0x0040).
- rst asserted during WAIT_RSP: outputs return to reset values next cycle; fetch restarts at 0x0000.
- With FETCH_BYPASS_EN, empty FIFO, ready=1: instr_valid_o same cycle as imem_rvalid_i with instr_o = imem_rdata_i (e.g. 0x00500093).
